apb3_requester_core: RTL and testbench
======================================

APB3_REQUESTER_CORE -- requirements
Module: apb3_requester_core

Interface
REQ-001 SHALL have parameter AddressWidth, default 32: width of the command address and of paddr.
REQ-002 SHALL have parameter DataWidth, default 32: width of the write data, read data, pwdata and prdata.
REQ-003 SHALL have parameter TimeoutCycles, default 256: maximum number of ACCESS cycles without pready; 0 disables the timeout.
REQ-004 SHALL have port clk, input, 1: clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have ports cmd_valid input 1, and cmd_ready output 1: command handshake.
REQ-007 SHALL have ports cmd_addr input AddressWidth, cmd_write input 1, and cmd_wdata input DataWidth: command payload.
REQ-008 SHALL have ports rsp_valid output 1, and rsp_ready input 1: response handshake.
REQ-009 SHALL have ports rsp_rdata output DataWidth, rsp_error output 1, and rsp_timeout output 1: response payload.
REQ-010 SHALL have ports paddr output AddressWidth, pselx output 1, penable output 1, pwrite output 1, and pwdata output DataWidth: APB3 requester outputs.
REQ-011 SHALL have ports pready input 1, prdata input DataWidth, and pslverr input 1: APB3 completer returns.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, ACCESS and RESP, with reset state IDLE.
REQ-013 SHALL drive cmd_ready=1 only in IDLE and accept a command at a rising edge where cmd_valid&cmd_ready is high.
REQ-014 SHALL, on command accept, register cmd_addr, cmd_write and cmd_wdata into paddr, pwrite and pwdata, then move to SETUP.
REQ-015 SHALL drive, in SETUP, pselx=1 and penable=0 for exactly one cycle, then move to ACCESS unconditionally.
REQ-016 SHALL drive, in ACCESS, pselx=1 and penable=1 until pready=1 is sampled.
REQ-017 SHALL, when pready=1 is sampled in ACCESS:
- capture pslverr into rsp_error;
- capture prdata into rsp_rdata for reads, or 0 for writes;
- clear rsp_timeout;
- move to RESP.
REQ-018 SHALL hold paddr, pwrite and pwdata stable from SETUP through the last ACCESS cycle; the values are then held until the next accept.
REQ-019 SHALL drive, in RESP, rsp_valid=1 with pselx=0 and penable=0, and hold rsp_valid and the payload stable until rsp_ready=1 is sampled, then move to IDLE.
REQ-020 SHALL meet this timing: command accepted at edge N gives SETUP in cycle N+1, ACCESS in N+2, and (with zero wait states) rsp_valid=1 in N+3; each pready=0 cycle adds one cycle.
REQ-021 SHALL count ACCESS cycles in a counter of width $clog2(TimeoutCycles+1), cleared on entry to SETUP.
REQ-022 SHALL, when TimeoutCycles>0 and the counter reaches TimeoutCycles with pready=0, abort to RESP with rsp_error=1, rsp_timeout=1 and rsp_rdata=0.
REQ-023 SHALL give pready=1 priority over the timeout when both occur in the same cycle.
REQ-024 SHALL ignore pready, prdata and pslverr outside ACCESS.
REQ-025 SHALL NOT accept a new command while in SETUP, ACCESS or RESP, since cmd_ready=0 in those states.

Reset
REQ-026 SHALL, on rst_n=0, immediately force all of the following to 0:
- outputs cmd_ready, rsp_valid, pselx, penable, pwrite, paddr, pwdata, rsp_rdata, rsp_error and rsp_timeout;
- the timeout counter;
- the FSM, to IDLE.
REQ-027 SHALL discard any in-flight transfer or pending response when reset is asserted mid-operation, with no response delivered after reset.
REQ-028 SHALL drive cmd_ready=1 in the first cycle after rst_n deassertion.

Structure
REQ-029 SHALL define the FSM state enum in the shared package apb3_pkg, alongside the APB3 address and data typedefs used by the completer and requester blocks.
REQ-030 SHALL place the timeout counter in the sub-module apb3_wait_timer, with inputs clear and enable and output expired; all other logic is in the top module.

Verification
REQ-031 SHALL cover a write with zero wait states: cmd addr=0x10, wdata=0xDEADBEEF, write=1, pready=1 -> pselx in N+1..N+2, penable in N+2, rsp_valid in N+3, rsp_error=0, rsp_rdata=0.
REQ-032 SHALL cover a read with 3 wait states: addr=0x20, pready low for 3 ACCESS cycles, then prdata=0x12345678 -> penable high for 4 cycles, paddr stable, rsp_rdata=0x12345678.
REQ-033 SHALL cover a slave error: read with pslverr=1 alongside pready -> rsp_error=1, rsp_timeout=0.
REQ-034 SHALL cover a timeout: TimeoutCycles=4, pready held 0 -> after 4 ACCESS cycles pselx=0, rsp_error=1, rsp_timeout=1, rsp_rdata=0.
REQ-035 SHALL cover response backpressure: rsp_ready low for 5 cycles -> rsp_valid and payload stable, cmd_ready=0 throughout, and cmd_ready=1 the cycle after the rsp handshake.
REQ-036 SHALL cover reset mid-ACCESS: rst_n pulsed low -> pselx, penable and rsp_valid are 0 immediately, and no response appears after release.

Source files
------------

// File: rtl/apb3_pkg.sv
// Shared APB3 types: FSM state encoding, default bus widths and a width helper for the wait timer.
package apb3_pkg;

    localparam int unsigned APB3_ADDR_W = 32;
    localparam int unsigned APB3_DATA_W = 32;

    typedef logic [APB3_ADDR_W-1:0] apb3_addr_t;
    typedef logic [APB3_DATA_W-1:0] apb3_data_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb3_state_e;

    // A disabled timer (0 cycles) still needs a 1-bit counter to stay legal.
    function automatic int unsigned timer_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/apb3_wait_timer.sv
// Counts ACCESS cycles of one transfer; expired flags the last allowed cycle without pready.
module apb3_wait_timer
    import apb3_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned    CntW    = timer_width(TimeoutCycles);
    localparam bit             TimerOn = (TimeoutCycles != 0);
    localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
    localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutCycles);

    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CntMax)) begin
            count_d = count_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds completed ACCESS cycles, so the current one is the N-th when count_q == N-1.
    assign expired = TimerOn && enable && (count_q == CntLast);

endmodule

// File: rtl/apb3_requester_core.sv
// APB3 requester: one command in, one SETUP/ACCESS transfer out, one response back, with wait-state timeout.
module apb3_requester_core
    import apb3_pkg::*;
#(
    parameter int unsigned AddressWidth  = APB3_ADDR_W,
    parameter int unsigned DataWidth     = APB3_DATA_W,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [AddressWidth-1:0] cmd_addr,
    input  logic                    cmd_write,
    input  logic [DataWidth-1:0]    cmd_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DataWidth-1:0]    rsp_rdata,
    output logic                    rsp_error,
    output logic                    rsp_timeout,
    output logic [AddressWidth-1:0] paddr,
    output logic                    pselx,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DataWidth-1:0]    pwdata,
    input  logic                    pready,
    input  logic [DataWidth-1:0]    prdata,
    input  logic                    pslverr
);

    apb3_state_e             state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    pselx_q, pselx_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [AddressWidth-1:0] paddr_q, paddr_d;
    logic [DataWidth-1:0]    pwdata_q, pwdata_d;
    logic [DataWidth-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_error_q, rsp_error_d;
    logic                    rsp_timeout_q, rsp_timeout_d;

    logic accept;
    logic timer_expired;

    assign accept = cmd_valid && cmd_ready_q;

    apb3_wait_timer #(
        .TimeoutCycles(TimeoutCycles)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .enable (state_q == ST_ACCESS),
        .expired(timer_expired)
    );

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = rsp_valid_q;
        pselx_d       = pselx_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (accept) begin
                    paddr_d     = cmd_addr;
                    pwrite_d    = cmd_write;
                    pwdata_d    = cmd_wdata;
                    cmd_ready_d = 1'b0;
                    pselx_d     = 1'b1;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // pready is checked first so a completion on the final allowed cycle is not a timeout.
                if (pready || timer_expired) begin
                    if (pready) begin
                        rsp_error_d   = pslverr;
                        rsp_rdata_d   = pwrite_q ? '0 : prdata;
                        rsp_timeout_d = 1'b0;
                    end else begin
                        rsp_error_d   = 1'b1;
                        rsp_rdata_d   = '0;
                        rsp_timeout_d = 1'b1;
                    end
                    pselx_d     = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            pselx_q       <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            pselx_q       <= pselx_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign pselx       = pselx_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb3_requester_core.sv
// Bench for apb3_requester_core: acts as APB3 completer and response sink, checks a vector table and random transfers.
module tb_apb3_requester_core;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_error, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] paddr, pwdata, prdata;
    logic        pselx, penable, pwrite, pready, pslverr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb3_requester_core #(
        .AddressWidth (32),
        .DataWidth    (32),
        .TimeoutCycles(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_write  (cmd_write),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .rsp_timeout(rsp_timeout),
        .paddr      (paddr),
        .pselx      (pselx),
        .penable    (penable),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .pready     (pready),
        .prdata     (prdata),
        .pslverr    (pslverr)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        slverr;
        int          waits;
        int          rsp_delay;
        int          exp_acc;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
    } vec_t;

    vec_t table_v[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Completer returns outside ACCESS are noise the requester must ignore.
    task automatic junk();
        pready  = 1'($urandom);
        prdata  = $urandom;
        pslverr = 1'($urandom);
    endtask

    // Reference model: derived from wait count and timeout limit, not from any state machine.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_to    = (v.waits >= TO);
        r.exp_acc   = r.exp_to ? TO : v.waits + 1;
        r.exp_err   = r.exp_to || v.slverr;
        r.exp_rdata = (r.exp_to || v.write) ? 32'h0 : v.rdata;
        return r;
    endfunction

    task automatic run_txn(input vec_t v, input int id);
        int acc;
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = v.addr;
        cmd_write = v.write;
        cmd_wdata = v.wdata;
        junk();
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_write = 1'($urandom);
        junk();
        chk("setup_psel_pen", {pselx, penable}, 2'b10);
        chk("setup_paddr", paddr, v.addr);
        chk("setup_pwrite", pwrite, v.write);
        if (v.write) chk("setup_pwdata", pwdata, v.wdata);
        chk("setup_cmd_ready", cmd_ready, 0);
        acc = 0;
        @(negedge clk);
        while (pselx && penable && acc < 20) begin
            acc++;
            chk("access_paddr", paddr, v.addr);
            if (v.write) chk("access_pwdata", pwdata, v.wdata);
            if (acc > v.waits) begin
                pready  = 1'b1;
                prdata  = v.rdata;
                pslverr = v.slverr;
            end else begin
                pready  = 1'b0;
                prdata  = $urandom;
                pslverr = 1'($urandom);
            end
            @(negedge clk);
        end
        junk();
        chk("access_cycles", acc, v.exp_acc);
        chk("resp_valid", rsp_valid, 1);
        chk("resp_psel_pen", {pselx, penable}, 2'b00);
        chk("resp_rdata", rsp_rdata, v.exp_rdata);
        chk("resp_error", rsp_error, v.exp_err);
        chk("resp_timeout", rsp_timeout, v.exp_to);
        chk("resp_cmd_ready", cmd_ready, 0);
        for (int d = 0; d < v.rsp_delay; d++) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            junk();
            chk("bp_stable", {rsp_valid, rsp_error, rsp_timeout, cmd_ready, rsp_rdata},
                {1'b1, v.exp_err, v.exp_to, 1'b0, v.exp_rdata});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_hs_idle", {rsp_valid, cmd_ready}, 2'b01);
        $display("txn %0d: %s addr=%h waits=%0d acc=%0d rdata=%h err=%0d to=%0d",
                 id, v.write ? "WR" : "RD", v.addr, v.waits, acc, rsp_rdata, rsp_error, rsp_timeout);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_write = 1'b0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;

        //                 wr    addr          wdata         rdata         slv  w   bp acc exp_rdata     err  to
        table_v[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 32'hAAAA5555, 1'b0, 0,  0, 1, 32'h0,        1'b0, 1'b0};
        table_v[1] = '{1'b0, 32'h20, 32'h0,        32'h12345678, 1'b0, 3,  0, 4, 32'h12345678, 1'b0, 1'b0};
        table_v[2] = '{1'b0, 32'h30, 32'h0,        32'hCAFEF00D, 1'b1, 1,  0, 2, 32'hCAFEF00D, 1'b1, 1'b0};
        table_v[3] = '{1'b0, 32'h40, 32'h0,        32'h55AA55AA, 1'b0, 10, 0, 4, 32'h0,        1'b1, 1'b1};
        table_v[4] = '{1'b1, 32'h50, 32'h0BADC0DE, 32'h11111111, 1'b0, 2,  5, 3, 32'h0,        1'b0, 1'b0};
        table_v[5] = '{1'b1, 32'h64, 32'h87654321, 32'h22222222, 1'b1, 0,  1, 1, 32'h0,        1'b1, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_ctrl", {cmd_ready, rsp_valid, pselx, penable, pwrite, rsp_error, rsp_timeout}, 0);
        chk("reset_data", {paddr, pwdata}, 0);
        chk("reset_rdata", rsp_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_cycle_cmd_ready", cmd_ready, 1);

        foreach (table_v[i]) run_txn(table_v[i], i);

        for (int i = 0; i < 40; i++) begin
            v.write     = 1'($urandom);
            v.addr      = $urandom;
            v.wdata     = $urandom;
            v.rdata     = $urandom;
            v.slverr    = 1'($urandom);
            v.waits     = $urandom_range(0, 6);
            v.rsp_delay = $urandom_range(0, 3);
            run_txn(model(v), 100 + i);
        end

        // Reset asserted in the middle of ACCESS: outputs drop at once and nothing is delivered later.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = 32'h60;
        cmd_write = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        pready    = 1'b0;
        @(negedge clk);
        chk("mid_access", {pselx, penable}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outs", {pselx, penable, rsp_valid, cmd_ready}, 0);
        chk("async_reset_paddr", paddr, 0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        pready  = 1'b1;
        prdata  = 32'hFFFFFFFF;
        @(negedge clk);
        chk("rerelease_cmd_ready", cmd_ready, 1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("no_rsp_after_reset", {rsp_valid, pselx, penable}, 0);
        end
        $display("txn reset_mid_access: done");

        run_txn(table_v[1], 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
